width_upsizer: RTL and testbench



---
 rtl/width_upsizer.sv | 115 +++++++++++
 tb/tb_width_upsizer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/width_upsizer.sv
// width_upsizer: packs RATIO consecutive IN_W-bit beats into one registered IN_W*RATIO-bit word.
// Latency: 1 clk from accepting the word-closing beat to valid_out; earlier beats only fill the accumulator.
// Backpressure: only the word-closing beat waits for a free output slot; ready_in is combinational in ready_out.
// Optional: define WIDTH_UPSIZER_LAST_EN to add last_in (early word close) and keep_out (lane-fill mask).
module width_upsizer #(
   parameter int IN_W      = 8,
   parameter int RATIO     = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   output logic                  ready_in,
   input  logic [IN_W-1:0]       data_in,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic [IN_W*RATIO-1:0] data_out
`ifdef WIDTH_UPSIZER_LAST_EN
   ,
   input  logic                  last_in,
   output logic [RATIO-1:0]      keep_out
`endif
);

   localparam int OUT_W = IN_W * RATIO;
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0] cnt;        // index of the lane the next accepted beat fills
   logic [OUT_W-1:0] acc;        // lanes already filled for the word in progress
   logic [OUT_W-1:0] beat_word;  // data_in shifted into lane cnt, zeros elsewhere
   logic             closing;    // the beat on data_in would complete the word
   logic             accept;

   // Bit position of lane k's least significant bit for the chosen lane order.
   function automatic int lane_lsb(input int k);
      if (MSB_FIRST != 0) begin
         return (RATIO - 1 - k) * IN_W;
      end
      return k * IN_W;
   endfunction

   // Place the incoming beat into its lane so it can be OR-ed into the accumulator.
   always_comb begin
      beat_word = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (cnt == CNT_W'(k)) begin
            beat_word[lane_lsb(k) +: IN_W] = data_in;
         end
      end
   end

`ifdef WIDTH_UPSIZER_LAST_EN
   assign closing = (cnt == CNT_LAST) || last_in;
`else
   assign closing = (cnt == CNT_LAST);
`endif

   // Non-closing beats never need the output slot, so they are always taken.
   // A closing beat may enter when the slot is empty or is being drained this cycle.
   assign ready_in = !closing || !valid_out || ready_out;
   assign accept   = valid_in && ready_in;

   // Beat counter and partial-word accumulator; idle cycles leave both untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         if (closing) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc | beat_word;
         end
      end
   end

   // Output slot: load on a closing beat, otherwise release once the consumer takes it.
   // data_out is deliberately left holding the last word after valid_out drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
      end else if (accept && closing) begin
         valid_out <= 1'b1;
         data_out  <= acc | beat_word;
      end else if (ready_out) begin
         valid_out <= 1'b0;
      end
   end

`ifdef WIDTH_UPSIZER_LAST_EN
   logic [RATIO-1:0] fill_mask;  // lanes 0..cnt, i.e. those holding data once this beat lands

   // Lanes up to and including the current one are valid in a word closed now.
   always_comb begin
      fill_mask = '0;
      for (int k = 0; k < RATIO; k++) begin
         fill_mask[k] = (CNT_W'(k) <= cnt);
      end
   end

   // keep_out travels with data_out and is loaded on the same closing beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keep_out <= '0;
      end else if (accept && closing) begin
         keep_out <= fill_mask;
      end
   end
`endif

endmodule

// File: tb/tb_width_upsizer.sv
// tb_width_upsizer: directed vector tables plus hand sequences for width_upsizer.
// Instance a: IN_W=8 RATIO=2 MSB first. Instance b: IN_W=8 RATIO=4 LSB first.
// Instance c (WIDTH_UPSIZER_LAST_EN builds only): IN_W=8 RATIO=4 MSB first with last_in/keep_out.
module tb_width_upsizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        a_valid, a_ready, a_vout, a_rout;
   logic [7:0]  a_din;
   logic [15:0] a_dout;

   logic        b_valid, b_ready, b_vout, b_rout;
   logic [7:0]  b_din;
   logic [31:0] b_dout;

`ifdef WIDTH_UPSIZER_LAST_EN
   logic [1:0]  a_keep;
   logic [3:0]  b_keep;
   logic        c_valid, c_ready, c_vout, c_rout, c_last;
   logic [7:0]  c_din;
   logic [31:0] c_dout;
   logic [3:0]  c_keep;
`endif

   width_upsizer #(.IN_W(8), .RATIO(2), .MSB_FIRST(1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .valid_in(a_valid), .ready_in(a_ready), .data_in(a_din),
      .valid_out(a_vout), .ready_out(a_rout), .data_out(a_dout)
`ifdef WIDTH_UPSIZER_LAST_EN
      , .last_in(1'b0), .keep_out(a_keep)
`endif
   );

   width_upsizer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .valid_in(b_valid), .ready_in(b_ready), .data_in(b_din),
      .valid_out(b_vout), .ready_out(b_rout), .data_out(b_dout)
`ifdef WIDTH_UPSIZER_LAST_EN
      , .last_in(1'b0), .keep_out(b_keep)
`endif
   );

`ifdef WIDTH_UPSIZER_LAST_EN
   width_upsizer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_c (
      .clk(clk), .rst_n(rst_n),
      .valid_in(c_valid), .ready_in(c_ready), .data_in(c_din),
      .valid_out(c_vout), .ready_out(c_rout), .data_out(c_dout),
      .last_in(c_last), .keep_out(c_keep)
   );
`endif

   typedef struct packed {
      logic        vld;
      logic [7:0]  dat;
      logic        rout;
      logic        e_rdy;
      logic        e_vout;
      logic [31:0] e_dat;
   } vec_t;

   vec_t va[18];
   vec_t vb[18];

   int total = 0;
   int bad   = 0;

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic ro,
                               input logic er, input logic ev, input logic [31:0] ed);
      vec_t r;
      r.vld = v; r.dat = d; r.rout = ro; r.e_rdy = er; r.e_vout = ev; r.e_dat = ed;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      // Instance a: basic pack, gap tolerance, backpressure with same-cycle drain.
      va[0]  = mk(0, 8'h00, 1, 1, 0, 32'h0000);
      va[1]  = mk(1, 8'hA0, 1, 1, 0, 32'h0000);
      va[2]  = mk(1, 8'hA1, 1, 1, 0, 32'h0000);
      va[3]  = mk(0, 8'h00, 1, 1, 1, 32'hA0A1);
      va[4]  = mk(1, 8'hB0, 1, 1, 0, 32'hA0A1);
      va[5]  = mk(0, 8'h00, 1, 1, 0, 32'hA0A1);
      va[6]  = mk(0, 8'h00, 1, 1, 0, 32'hA0A1);
      va[7]  = mk(1, 8'hB1, 1, 1, 0, 32'hA0A1);
      va[8]  = mk(0, 8'h00, 1, 1, 1, 32'hB0B1);
      va[9]  = mk(0, 8'h00, 0, 1, 0, 32'hB0B1);
      va[10] = mk(1, 8'h01, 0, 1, 0, 32'hB0B1);
      va[11] = mk(1, 8'h02, 0, 1, 0, 32'hB0B1);
      va[12] = mk(1, 8'h03, 0, 1, 1, 32'h0102);
      va[13] = mk(1, 8'h04, 0, 0, 1, 32'h0102);
      va[14] = mk(1, 8'h04, 0, 0, 1, 32'h0102);
      va[15] = mk(1, 8'h04, 1, 1, 1, 32'h0102);
      va[16] = mk(0, 8'h00, 1, 1, 1, 32'h0304);
      va[17] = mk(0, 8'h00, 1, 1, 0, 32'h0304);

      // Instance b: LSB-first lane order, non-final beats taken while the slot is stalled.
      vb[0]  = mk(0, 8'h00, 1, 1, 0, 32'h00000000);
      vb[1]  = mk(1, 8'h11, 1, 1, 0, 32'h00000000);
      vb[2]  = mk(1, 8'h22, 1, 1, 0, 32'h00000000);
      vb[3]  = mk(1, 8'h33, 1, 1, 0, 32'h00000000);
      vb[4]  = mk(1, 8'h44, 1, 1, 0, 32'h00000000);
      vb[5]  = mk(0, 8'h00, 1, 1, 1, 32'h44332211);
      vb[6]  = mk(0, 8'h00, 0, 1, 0, 32'h44332211);
      vb[7]  = mk(1, 8'h55, 0, 1, 0, 32'h44332211);
      vb[8]  = mk(1, 8'h66, 0, 1, 0, 32'h44332211);
      vb[9]  = mk(1, 8'h77, 0, 1, 0, 32'h44332211);
      vb[10] = mk(1, 8'h88, 0, 1, 0, 32'h44332211);
      vb[11] = mk(1, 8'h99, 0, 1, 1, 32'h88776655);
      vb[12] = mk(1, 8'hAA, 0, 1, 1, 32'h88776655);
      vb[13] = mk(1, 8'hBB, 0, 1, 1, 32'h88776655);
      vb[14] = mk(1, 8'hCC, 0, 0, 1, 32'h88776655);
      vb[15] = mk(1, 8'hCC, 1, 1, 1, 32'h88776655);
      vb[16] = mk(0, 8'h00, 1, 1, 1, 32'hCCBBAA99);
      vb[17] = mk(0, 8'h00, 1, 1, 0, 32'hCCBBAA99);

      rst_n   = 1'b0;
      a_valid = 1'b0; a_din = '0; a_rout = 1'b1;
      b_valid = 1'b0; b_din = '0; b_rout = 1'b1;
`ifdef WIDTH_UPSIZER_LAST_EN
      c_valid = 1'b0; c_din = '0; c_rout = 1'b1; c_last = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         a_valid = va[i].vld; a_din = va[i].dat; a_rout = va[i].rout;
         #1;
         chk($sformatf("a[%0d].ready_in", i),  32'(a_ready), 32'(va[i].e_rdy));
         chk($sformatf("a[%0d].valid_out", i), 32'(a_vout),  32'(va[i].e_vout));
         chk($sformatf("a[%0d].data_out", i),  32'(a_dout),  va[i].e_dat);
      end
      a_valid = 1'b0; a_rout = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         b_valid = vb[i].vld; b_din = vb[i].dat; b_rout = vb[i].rout;
         #1;
         chk($sformatf("b[%0d].ready_in", i),  32'(b_ready), 32'(vb[i].e_rdy));
         chk($sformatf("b[%0d].valid_out", i), 32'(b_vout),  32'(vb[i].e_vout));
         chk($sformatf("b[%0d].data_out", i),  b_dout,       vb[i].e_dat);
      end
      b_valid = 1'b0; b_rout = 1'b1;

      // Reset mid-word with a stalled output pending: E0E1 waits, C0 is partial.
      @(posedge clk); #1; a_valid = 1'b1; a_din = 8'hE0; a_rout = 1'b0;
      @(posedge clk); #1; a_din = 8'hE1;
      @(posedge clk); #1; a_din = 8'hC0;
      #1;
      chk("rst.pre_valid_out", 32'(a_vout), 32'd1);
      chk("rst.pre_data_out",  32'(a_dout), 32'hE0E1);
      @(posedge clk); #1; a_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("rst.valid_out_async", 32'(a_vout),  32'd0);
      chk("rst.data_out_async",  32'(a_dout),  32'h0000);
      chk("rst.ready_in_async",  32'(a_ready), 32'd1);
      #2 rst_n = 1'b1;
      @(posedge clk); #1; a_valid = 1'b1; a_din = 8'hD0; a_rout = 1'b1;
      @(posedge clk); #1; a_din = 8'hD1;
      @(posedge clk); #1; a_valid = 1'b0;
      #1;
      chk("rst.after_valid_out", 32'(a_vout), 32'd1);
      chk("rst.after_data_out",  32'(a_dout), 32'hD0D1);

`ifdef WIDTH_UPSIZER_LAST_EN
      // Early close on last_in, then a full word.
      chk("last.keep_reset", 32'(c_keep), 32'h0);
      @(posedge clk); #1; c_valid = 1'b1; c_din = 8'hAA; c_last = 1'b0;
      @(posedge clk); #1; c_din = 8'hBB; c_last = 1'b1;
      #1;
      chk("last.ready_in", 32'(c_ready), 32'd1);
      @(posedge clk); #1; c_valid = 1'b0; c_last = 1'b0;
      #1;
      chk("last.valid_out", 32'(c_vout), 32'd1);
      chk("last.data_out",  c_dout,      32'hAABB0000);
      chk("last.keep_out",  32'(c_keep), 32'h3);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1; c_valid = 1'b1; c_din = 8'(i);
      end
      @(posedge clk); #1; c_valid = 1'b0;
      #1;
      chk("full.valid_out", 32'(c_vout), 32'd1);
      chk("full.data_out",  c_dout,      32'h01020304);
      chk("full.keep_out",  32'(c_keep), 32'hF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
